// File: rtl/md_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// func3 opcodes and the FSM state encoding.
package md_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on a shared 2*XLEN+1 bit accumulator.
module muldiv_unit
  import md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam int AW = 2 * XLEN + 1;

  md_state_e         state_r, state_next_s;
  logic [CW-1:0]     cnt_r;
  logic [2:0]        func3_r;
  logic [XLEN-1:0]   divisor_r;
  logic [AW-1:0]     acc_r;
  logic              neg_r;
  logic [XLEN-1:0]   result_r;
  logic              out_valid_r;
  logic              in_ready_r;

  logic              accept_s;
  logic              a_neg_s, b_neg_s, neg_in_s;
  logic [XLEN-1:0]   abs_a_s, abs_b_s;
  logic              div_zero_s, ovf_s, special_s;
  logic [XLEN-1:0]   special_val_s;
  logic              is_div_s;
  logic [XLEN:0]     opnd_s, addend_s, sum_s;
  logic              cin_s;
  logic [AW-1:0]     acc_iter_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   div_sel_s, div_fix_s, fix_val_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;

  // Request decode: operand magnitudes, result sign and special cases.
  always_comb begin
    accept_s   = in_valid && (state_r == IDLE) && !flush;
    a_neg_s    = op_a[XLEN-1] && ((func3 == F3_MULH) || (func3 == F3_MULHSU) ||
                                  (func3 == F3_DIV)  || (func3 == F3_REM));
    b_neg_s    = op_b[XLEN-1] && ((func3 == F3_MULH) || (func3 == F3_DIV) ||
                                  (func3 == F3_REM));
    abs_a_s    = a_neg_s ? -op_a : op_a;
    abs_b_s    = b_neg_s ? -op_b : op_b;
    // Remainder follows the dividend; everything else is sign(a) ^ sign(b).
    neg_in_s   = (func3 == F3_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
    div_zero_s = func3[2] && (op_b == {XLEN{1'b0}});
    ovf_s      = ((func3 == F3_DIV) || (func3 == F3_REM)) &&
                 (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == {XLEN{1'b1}});
    special_s  = div_zero_s || ovf_s;
    case (func3)
      F3_DIV, F3_DIVU: special_val_s = div_zero_s ? {XLEN{1'b1}} : op_a;
      F3_REM, F3_REMU: special_val_s = div_zero_s ? op_a : {XLEN{1'b0}};
      default:         special_val_s = {XLEN{1'b0}};
    endcase
  end

  // Shared iteration datapath: one adder serves both add and trial-subtract.
  always_comb begin
    is_div_s = func3_r[2];
    if (is_div_s) begin
      opnd_s   = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
      addend_s = ~{1'b0, divisor_r};
      cin_s    = 1'b1;
    end else begin
      opnd_s   = acc_r[AW-1:XLEN];
      addend_s = acc_r[0] ? {1'b0, divisor_r} : {(XLEN+1){1'b0}};
      cin_s    = 1'b0;
    end
    sum_s = opnd_s + addend_s + {{XLEN{1'b0}}, cin_s};
    if (!is_div_s) begin
      acc_iter_s = {1'b0, sum_s, acc_r[XLEN-1:1]};
    end else if (!sum_s[XLEN]) begin
      acc_iter_s = {sum_s, acc_r[XLEN-2:0], 1'b1};
    end else begin
      acc_iter_s = {acc_r[2*XLEN-1:0], 1'b0};
    end
  end

  // Final sign correction and result selection.
  always_comb begin
    prod_fix_s = neg_r ? -acc_r[2*XLEN-1:0] : acc_r[2*XLEN-1:0];
    div_sel_s  = func3_r[1] ? acc_r[2*XLEN-1:XLEN] : acc_r[XLEN-1:0];
    div_fix_s  = neg_r ? -div_sel_s : div_sel_s;
    case (func3_r)
      F3_MUL:                        fix_val_s = prod_fix_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_val_s = prod_fix_s[2*XLEN-1:XLEN];
      default:                       fix_val_s = div_fix_s;
    endcase
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_next_s = in_valid ? (special_s ? DONE : CALC) : IDLE;
        CALC:    state_next_s = (cnt_r == CW'(XLEN - 1)) ? FIX : CALC;
        FIX:     state_next_s = DONE;
        DONE:    state_next_s = out_ready ? IDLE : DONE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, iteration counter, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= {CW{1'b0}};
      func3_r     <= 3'b000;
      divisor_r   <= {XLEN{1'b0}};
      acc_r       <= {AW{1'b0}};
      neg_r       <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      out_valid_r <= (state_next_s == DONE);
      in_ready_r  <= (state_next_s == IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            func3_r   <= func3;
            divisor_r <= abs_b_s;
            neg_r     <= neg_in_s;
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {{(XLEN+1){1'b0}}, abs_a_s};
            if (special_s) begin
              result_r <= special_val_s;
            end
          end
        end
        CALC: begin
          acc_r <= acc_iter_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        FIX: begin
          if (!flush) begin
            result_r <= fix_val_s;
          end
          cnt_r <= {CW{1'b0}};
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; even, >= 8.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port func3, input, 3, RV32M op select:
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-007 SHALL have port op_a, input, XLEN, rs1 value.
REQ-008 SHALL have port op_b, input, XLEN, rs2 value.
REQ-009 SHALL have port flush, input, 1, abort the in-flight op.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port result, output, XLEN, op result.

Function
REQ-013 SHALL use FSM states IDLE, CALC, FIX, DONE.
REQ-014 SHALL assert in_ready only in IDLE; accept when in_valid && in_ready at a rising edge; latch func3, op_a, op_b.
REQ-015 On accept: SHALL take absolute values of signed operands (MULH both; MULHSU op_a only; DIV/REM both) and record result sign; then go to CALC with counter = 0.
REQ-016 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) iteration per cycle, exactly XLEN iterations, then go to FIX.
REQ-017 Multiply SHALL form the full 2*XLEN product internally:
- MUL returns the low XLEN bits.
- MULH, MULHSU, MULHU return the high XLEN bits.
REQ-018 FIX SHALL apply two's-complement sign correction and select quotient or remainder:
- Quotient sign = sign(a) XOR sign(b).
- Remainder sign = sign(a).
- The corrected value SHALL be registered into result; then go to DONE.
REQ-019 Latency SHALL be exactly XLEN+2 rising edges from the accepting edge to out_valid=1, except per REQ-020.
REQ-020 Special cases SHALL be detected at accept and go directly IDLE->DONE, with out_valid after 1 edge:
- Divisor 0: DIV/DIVU give all-ones; REM/REMU give op_a.
- Signed overflow (op_a = 2^(XLEN-1), op_b = all-ones): DIV gives op_a; REM gives 0.
REQ-021 In DONE: out_valid=1 and result SHALL hold stable until out_ready=1; DONE && out_ready -> IDLE at that edge; no new accept in that same cycle.
REQ-022 flush=1 at any edge SHALL force IDLE and clear out_valid, discarding the result. flush has priority over accept and completion; flush with in_valid in IDLE SHALL not accept.
REQ-023 All arithmetic SHALL be modulo 2^XLEN on outputs; internal accumulator is 2*XLEN+1 bits wide.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, counter 0, result 0, out_valid 0, in_ready 1 next cycle, regardless of state (including mid-CALC).
REQ-025 rst SHALL have priority over flush and all handshakes.

Structure
REQ-026 Shared package md_pkg SHALL hold the func3 opcode constants and the FSM state type/encoding.
REQ-027 The block SHALL be a single module; no sub-module. The iteration datapath is shared between multiply and divide.

Verification (XLEN=32)
REQ-028 MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB; out_valid exactly 34 edges after accept.
REQ-029 MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
REQ-030 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-031 Special cases, each with out_valid 1 edge after accept:
- DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0; release -> IDLE next edge.
REQ-033 Abort: flush at CALC cycle 5 -> IDLE next edge, no out_valid. Same for rst at CALC cycle 5; then a new MUL 3 * 4 -> 12.
